input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_BTN, default 4: number of push-button channels with level and pulse outputs.
REQ-002 Parameter N_SW, default 13: number of switch channels with level output only (Din 8 + F 3 + R 2).
REQ-003 Parameter DB_CYCLES, default 50000: consecutive stable cycles required to accept a new level; legal range 1..65535.
REQ-004 Clk  input  1  system clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 btn_in  input  N_BTN  raw asynchronous push-button levels, active high.
REQ-007 sw_in  input  N_SW  raw asynchronous switch levels.
REQ-008 btn_level  output  N_BTN  debounced button levels, active high.
REQ-009 btn_pulse  output  N_BTN  one-cycle pulse per accepted 0->1 transition of btn_level.
REQ-010 sw_level  output  N_SW  debounced switch levels.

Function
REQ-011 Each channel SHALL pass its raw input through a two-flop synchronizer; the second flop output is the channel's synced value s.
REQ-012 Each channel SHALL hold an accepted level q and a counter cnt of width clog2(DB_CYCLES+1).
REQ-013 When s equals q, cnt SHALL be cleared to 0 on the next edge.
REQ-014 When s differs from q and cnt < DB_CYCLES-1, cnt SHALL increment by 1.
REQ-015 When s differs from q and cnt == DB_CYCLES-1, q SHALL take s and cnt SHALL clear to 0 on that edge.
REQ-016 Latency from a clean raw input step to the q change SHALL be exactly 2+DB_CYCLES rising edges.
REQ-017 A synced disturbance shorter than DB_CYCLES cycles SHALL leave q unchanged and SHALL return cnt to 0.
REQ-018 btn_pulse[i] SHALL be a registered output, high for exactly the one cycle following the edge on which btn_level[i] goes 0->1.
REQ-019 A 1->0 transition of btn_level SHALL produce no pulse.
REQ-020 A second pulse on a channel SHALL require btn_level to fall and rise again, each after full debounce.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on their own schedules.
REQ-022 With DB_CYCLES == 1, q SHALL follow s with one cycle of delay, 3 edges total from raw input.
REQ-023 cnt SHALL never wrap; it saturates at DB_CYCLES-1 by REQ-015.

Reset
REQ-024 Assertion of Reset_n low SHALL asynchronously clear all synchronizer flops, q, cnt and pulse registers to 0.
REQ-025 Outputs btn_level, btn_pulse and sw_level SHALL read all-zero during reset and on the first edge after release.
REQ-026 A reset in mid-count SHALL discard the partial count; counting restarts from 0 after release.
REQ-027 A button held high across reset release SHALL be accepted 2+DB_CYCLES edges after release and SHALL produce exactly one pulse.

Structure
REQ-028 Package proc_io_pkg SHALL hold N_BTN_DEFAULT, N_SW_DEFAULT, DB_CYCLES_DEFAULT and a function returning counter width.
REQ-029 One sub-module debounce_channel SHALL implement sync, counter and q for one bit, with parameter PULSE_EN selecting pulse generation.
REQ-030 input_conditioner SHALL instantiate debounce_channel as N_BTN pulse-enabled and N_SW pulse-disabled instances via generate loops.
REQ-031 No combinational path SHALL exist from any raw input to any output.

Verification
REQ-032 DB_CYCLES=4, btn_in[0] 0->1 held: btn_level[0] rises at edge 6, btn_pulse[0]=1 for exactly cycle 7, then 0.
REQ-033 DB_CYCLES=4, btn_in[1] high for 3 synced cycles, then low: btn_level[1] stays 0, no pulse, cnt returns to 0.
REQ-034 DB_CYCLES=4, sw_in=13'h1ABC stepped at once: sw_level==13'h1ABC after 6 edges; btn_pulse remains all-zero.
REQ-035 DB_CYCLES=4, btn_in[2] high, Reset_n pulsed low at count 2: outputs clear immediately; after release, btn_level[2] rises 6 edges later with one pulse.
REQ-036 DB_CYCLES=1, btn_in[3] toggled every 4 cycles: btn_level[3] tracks with 3-edge delay, one pulse per rising edge.
REQ-037 DB_CYCLES=4, btn_in[0] and btn_in[3] rise 2 cycles apart: pulses appear 2 cycles apart, each one cycle wide.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared defaults and sizing helper for the push-button / switch input conditioner.
package proc_io_pkg;

    localparam int N_BTN_DEFAULT     = 4;
    localparam int N_SW_DEFAULT      = 13;
    localparam int DB_CYCLES_DEFAULT = 50000;

    // Counter must hold values 0..DB_CYCLES-1 without wrapping.
    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: two-flop synchronizer, stability counter and accepted level,
// with an optional registered rising-edge pulse.
module debounce_channel
    import proc_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter bit PULSE_EN  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          s;
    logic          q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            q     <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            pulse <= 1'b0;
            if (s == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Input has differed for DB_CYCLES consecutive cycles: accept it.
                q     <= s;
                cnt   <= '0;
                pulse <= PULSE_EN & s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces N_BTN push buttons (level + rising pulse) and N_SW switches (level only).
module input_conditioner
    import proc_io_pkg::*;
#(
    parameter int N_BTN     = N_BTN_DEFAULT,
    parameter int N_SW      = N_SW_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_SW-1:0]  sw_level
);

    // Switch channels are built without pulse logic; their pulse ports are tied off here.
    logic [N_SW-1:0] sw_pulse_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .PULSE_EN  (1'b1)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_in[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .PULSE_EN  (1'b0)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_in[i]),
            .level (sw_level[i]),
            .pulse (sw_pulse_unused[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: one conditioner with DB_CYCLES=4 and one with DB_CYCLES=1.
module tb_input_conditioner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn_a, btn_b;
    logic [12:0] sw_a, sw_b;
    logic [3:0]  lvl_a, pls_a, lvl_b, pls_b;
    logic [12:0] swl_a, swl_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input_conditioner #(.N_BTN(4), .N_SW(13), .DB_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .sw_in(sw_a),
        .btn_level(lvl_a), .btn_pulse(pls_a), .sw_level(swl_a)
    );

    input_conditioner #(.N_BTN(4), .N_SW(13), .DB_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .sw_in(sw_b),
        .btn_level(lvl_b), .btn_pulse(pls_b), .sw_level(swl_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic raw_hist [0:39];

    function automatic logic hist(input int i);
        return (i < 0) ? 1'b0 : raw_hist[i];
    endfunction

    initial begin
        rst_n = 1'b0;
        btn_a = '0; sw_a = '0; btn_b = '0; sw_b = '0;
        #2;
        chk("rst_lvl_a", {28'd0, lvl_a}, 32'd0);
        chk("rst_pls_a", {28'd0, pls_a}, 32'd0);
        chk("rst_sw_a", {19'd0, swl_a}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rel_lvl", {28'd0, lvl_a}, 32'd0);
        chk("post_rel_pls", {28'd0, pls_a}, 32'd0);

        // Single button step: level at edge 6, pulse only in cycle 7.
        btn_a[0] = 1'b1;
        tick(5);
        chk("b0_e5_lvl", {28'd0, lvl_a}, 32'd0);
        tick(1);
        chk("b0_e6_lvl", {28'd0, lvl_a}, 32'h1);
        chk("b0_e6_pls", {28'd0, pls_a}, 32'h1);
        tick(1);
        chk("b0_e7_pls", {28'd0, pls_a}, 32'h0);
        chk("b0_e7_lvl", {28'd0, lvl_a}, 32'h1);
        btn_a[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("b0_fall_pls", {28'd0, pls_a}, 32'h0);
            chk("b0_fall_lvl", {28'd0, lvl_a}, (k < 6) ? 32'h1 : 32'h0);
        end

        // Glitch of 3 synced cycles: counter reaches 3 and returns to 0, no acceptance.
        btn_a[1] = 1'b1;
        tick(3);
        btn_a[1] = 1'b0;
        tick(2);
        chk("b1_cnt_peak", 32'(dut_a.g_btn[1].u_chan.cnt), 32'd3);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("b1_glitch_lvl", {28'd0, lvl_a}, 32'h0);
            chk("b1_glitch_pls", {28'd0, pls_a}, 32'h0);
        end
        chk("b1_cnt_end", 32'(dut_a.g_btn[1].u_chan.cnt), 32'd0);

        // Switch word stepped at once.
        sw_a = 13'h1ABC;
        tick(5);
        chk("sw_e5", {19'd0, swl_a}, 32'h0);
        chk("sw_e5_pls", {28'd0, pls_a}, 32'h0);
        tick(1);
        chk("sw_e6", {19'd0, swl_a}, 32'h1ABC);
        chk("sw_e6_pls", {28'd0, pls_a}, 32'h0);
        sw_a = 13'h0;
        tick(6);
        chk("sw_clear", {19'd0, swl_a}, 32'h0);

        // Buttons 0 and 3 rising two cycles apart.
        btn_a[0] = 1'b1;
        tick(2);
        btn_a[3] = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            tick(1);
            chk("b03_pls", {28'd0, pls_a}, (k == 6) ? 32'h1 : (k == 8) ? 32'h8 : 32'h0);
            chk("b03_lvl", {28'd0, lvl_a},
                (k < 6) ? 32'h0 : (k < 8) ? 32'h1 : 32'h9);
        end
        btn_a = '0;
        tick(8);
        chk("b03_clear", {28'd0, lvl_a}, 32'h0);

        // Reset in mid-count on button 2, with switches holding a nonzero level.
        sw_a = 13'h0F0F;
        tick(6);
        chk("sw_pre_rst", {19'd0, swl_a}, 32'h0F0F);
        btn_a[2] = 1'b1;
        tick(4);
        chk("b2_cnt_mid", 32'(dut_a.g_btn[2].u_chan.cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sw", {19'd0, swl_a}, 32'h0);
        chk("rst_mid_lvl", {28'd0, lvl_a}, 32'h0);
        chk("rst_mid_cnt", 32'(dut_a.g_btn[2].u_chan.cnt), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rel_e1_lvl", {28'd0, lvl_a}, 32'h0);
        chk("rel_e1_sw", {19'd0, swl_a}, 32'h0);
        tick(4);
        chk("rel_e5_lvl", {28'd0, lvl_a}, 32'h0);
        chk("rel_e5_pls", {28'd0, pls_a}, 32'h0);
        tick(1);
        chk("rel_e6_lvl", {28'd0, lvl_a}, 32'h4);
        chk("rel_e6_pls", {28'd0, pls_a}, 32'h4);
        chk("rel_e6_sw", {19'd0, swl_a}, 32'h0F0F);
        tick(1);
        chk("rel_e7_pls", {28'd0, pls_a}, 32'h0);
        tick(3);
        chk("rel_no_2nd_pls", {28'd0, pls_a}, 32'h0);

        // DB_CYCLES=1: button 3 toggles every 4 cycles, level lags raw by 3 edges.
        for (int k = 0; k < 32; k++) begin
            raw_hist[k] = ((k / 4) % 2) == 1;
            btn_b[3] = raw_hist[k];
            tick(1);
            chk("db1_lvl", {31'd0, lvl_b[3]}, {31'd0, hist(k - 2)});
            chk("db1_pls", {28'd0, pls_b}, {28'd0, hist(k - 2) & ~hist(k - 3), 3'b000});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
